// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned CNT_W_DEF  = 2;
   localparam int unsigned REG_ZERO   = 0;
   localparam int unsigned MAX_WR     = 4;

   // Index of the highest write port hitting an address (0 when none hit).
   function automatic int unsigned wr_sel(input logic [MAX_WR-1:0] hits);
      int unsigned sel = 0;
      for (int unsigned j = 0; j < MAX_WR; j++) begin
         if (hits[j]) sel = j;
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_sb_ctr.sv
// Pending-write counter for one architectural register.
module rf_pending_ctr
   import regfile_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             at_max,
   output logic             is_zero,
   output logic             underflow
);

   assign at_max    = (cnt == '1);
   assign is_zero   = (cnt == '0);
   assign underflow = dec && is_zero;

   // Issue and writeback in the same cycle cancel; saturate at both ends.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (inc && !dec && !at_max) begin
         cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc && !is_zero) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write forwarding and per-register
// pending-write scoreboard for RAW hazard stalls.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned N_RD   = 2,
   parameter int unsigned N_WR   = 2,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_RD*ADDR_W-1:0] rd_addr,
   output logic [N_RD*DATA_W-1:0] rd_data,
   output logic [N_RD-1:0]        rd_busy,
   input  logic [N_WR-1:0]        wr_en,
   input  logic [N_WR*ADDR_W-1:0] wr_addr,
   input  logic [N_WR*DATA_W-1:0] wr_data,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_addr,
   output logic                   iss_ready,
   output logic                   err_underflow
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem    [DEPTH];
   logic [DATA_W-1:0] wr_val [DEPTH];
   logic [CNT_W-1:0]  cnt    [DEPTH];
   logic [DEPTH-1:0]  wr_hit;
   logic [DEPTH-1:0]  at_max;
   logic [DEPTH-1:0]  is_zero;
   logic [DEPTH-1:0]  uflow;
   logic [MAX_WR-1:0] hits;
   int unsigned       sel;
   logic [ADDR_W-1:0] ra;

   // Resolve, per register, whether any port writes it and which port wins.
   // Collisions collapse to a single hit so the counter moves only once.
   always_comb begin
      hits = '0;
      sel  = 0;
      for (int unsigned a = 0; a < DEPTH; a++) begin
         hits = '0;
         for (int unsigned j = 0; j < N_WR; j++) begin
            hits[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(a));
         end
         sel       = wr_sel(hits);
         wr_hit[a] = (a != REG_ZERO) && (|hits);
         wr_val[a] = '0;
         for (int unsigned j = 0; j < N_WR; j++) begin
            if (j == sel) wr_val[a] = wr_data[j*DATA_W +: DATA_W];
         end
      end
   end

   // Storage: register 0 is never written, so it stays at its reset value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned a = 0; a < DEPTH; a++) mem[a] <= '0;
      end else begin
         for (int unsigned a = 1; a < DEPTH; a++) begin
            if (wr_hit[a]) mem[a] <= wr_val[a];
         end
      end
   end

   assign cnt[0]     = '0;
   assign at_max[0]  = 1'b0;
   assign is_zero[0] = 1'b1;
   assign uflow[0]   = 1'b0;

   for (genvar g = 1; g < DEPTH; g++) begin : g_ctr
      logic inc;
      assign inc = iss_en && iss_ready && (iss_addr == ADDR_W'(g));
      rf_pending_ctr #(.CNT_W(CNT_W)) u_ctr (
         .clk       (clk),
         .reset     (reset),
         .inc       (inc),
         .dec       (wr_hit[g]),
         .cnt       (cnt[g]),
         .at_max    (at_max[g]),
         .is_zero   (is_zero[g]),
         .underflow (uflow[g])
      );
   end

   // A saturated counter only accepts a new issue if a writeback frees a slot.
   assign iss_ready = !(at_max[iss_addr] && !wr_hit[iss_addr]);

   // Read ports with forwarding; a last outstanding write being satisfied
   // now is not a hazard since the forwarded value is final.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      for (int unsigned k = 0; k < N_RD; k++) begin
         ra = rd_addr[k*ADDR_W +: ADDR_W];
         if (!reset && (ra != ADDR_W'(REG_ZERO))) begin
            rd_data[k*DATA_W +: DATA_W] = wr_hit[ra] ? wr_val[ra] : mem[ra];
            rd_busy[k] = !is_zero[ra] && !((cnt[ra] == CNT_W'(1)) && wr_hit[ra]);
         end
      end
   end

   // Sticky underflow flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_underflow <= 1'b0;
      end else if (|uflow) begin
         err_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver pushes expected outputs from an
// array-based reference model, monitor pops and compares at negedge.
module tb_regfile_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int N_RD   = 2;
   localparam int N_WR   = 2;
   localparam int CNT_W  = 2;
   localparam int DEPTH  = 32;
   localparam int CMAX   = 3;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [N_RD*ADDR_W-1:0] rd_addr = '0;
   logic [N_RD*DATA_W-1:0] rd_data;
   logic [N_RD-1:0]        rd_busy;
   logic [N_WR-1:0]        wr_en = '0;
   logic [N_WR*ADDR_W-1:0] wr_addr = '0;
   logic [N_WR*DATA_W-1:0] wr_data = '0;
   logic                   iss_en = 1'b0;
   logic [ADDR_W-1:0]      iss_addr = '0;
   logic                   iss_ready;
   logic                   err_underflow;

   regfile_sb #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_WR(N_WR), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] d0, d1;
      logic        b0, b1, rdy, err;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;
   int step = 0;

   // reference model state
   logic [31:0] m_reg [DEPTH];
   int          m_cnt [DEPTH];
   bit          m_err;

   // inputs currently applied
   bit          v_rst = 1'b1;
   bit [1:0]    v_wen = '0;
   int          v_wa [2] = '{0, 0};
   logic [31:0] v_wd [2] = '{0, 0};
   int          v_ra [2] = '{0, 0};
   bit          v_ien = 1'b0;
   int          v_ia = 0;

   function automatic bit m_hit(int a);
      if (a == 0) return 1'b0;
      for (int j = 0; j < 2; j++) if (v_wen[j] && v_wa[j] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_read(int a);
      logic [31:0] r;
      if (a == 0) return 32'h0;
      r = m_reg[a];
      for (int j = 0; j < 2; j++) if (v_wen[j] && v_wa[j] == a) r = v_wd[j];
      return r;
   endfunction

   function automatic bit m_ready(int a);
      return !(a != 0 && m_cnt[a] == CMAX && !m_hit(a));
   endfunction

   function automatic bit m_busy(int a);
      return a != 0 && m_cnt[a] != 0 && !(m_cnt[a] == 1 && m_hit(a));
   endfunction

   task automatic m_clear();
      for (int a = 0; a < DEPTH; a++) begin
         m_reg[a] = 32'h0;
         m_cnt[a] = 0;
      end
      m_err = 1'b0;
   endtask

   // apply one clock edge of the currently driven inputs to the model
   task automatic m_commit();
      bit          inc_ok;
      bit          h, i;
      logic [31:0] nv [DEPTH];
      if (v_rst) begin
         m_clear();
         return;
      end
      inc_ok = v_ien && v_ia != 0 && m_ready(v_ia);
      for (int a = 0; a < DEPTH; a++) nv[a] = m_read(a);
      for (int a = 1; a < DEPTH; a++) begin
         h = m_hit(a);
         i = inc_ok && v_ia == a;
         if (h) begin
            m_reg[a] = nv[a];
            if (m_cnt[a] == 0) m_err = 1'b1;
         end
         if (h && !i && m_cnt[a] > 0) m_cnt[a]--;
         if (i && !h) m_cnt[a]++;
      end
   endtask

   task automatic apply(bit rst, bit [1:0] wen, int wa0, logic [31:0] wd0,
                        int wa1, logic [31:0] wd1, int ra0, int ra1,
                        bit ien, int ia);
      exp_t e;
      @(posedge clk);
      m_commit();
      #1;
      v_rst = rst; v_wen = wen; v_wa[0] = wa0; v_wa[1] = wa1;
      v_wd[0] = wd0; v_wd[1] = wd1; v_ra[0] = ra0; v_ra[1] = ra1;
      v_ien = ien; v_ia = ia;
      reset    = rst;
      wr_en    = wen;
      wr_addr  = {5'(wa1), 5'(wa0)};
      wr_data  = {wd1, wd0};
      rd_addr  = {5'(ra1), 5'(ra0)};
      iss_en   = ien;
      iss_addr = 5'(ia);
      if (rst) m_clear();
      step++;
      e.id = step;
      if (rst) begin
         e.d0 = 32'h0; e.d1 = 32'h0; e.b0 = 1'b0; e.b1 = 1'b0;
         e.rdy = 1'b1; e.err = 1'b0;
      end else begin
         e.d0 = m_read(ra0); e.d1 = m_read(ra1);
         e.b0 = m_busy(ra0); e.b1 = m_busy(ra1);
         e.rdy = m_ready(ia); e.err = m_err;
      end
      q.push_back(e);
   endtask

   task automatic idle_read(int ra0, int ra1);
      apply(1'b0, 2'b00, 0, 32'h0, 0, 32'h0, ra0, ra1, 1'b0, 0);
   endtask

   task automatic issue(int ia, int ra0);
      apply(1'b0, 2'b00, 0, 32'h0, 0, 32'h0, ra0, ra0, 1'b1, ia);
   endtask

   task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // monitor: outputs are stable half a cycle after the driver changes inputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_data0", e.id, rd_data[31:0], e.d0);
            chk("rd_data1", e.id, rd_data[63:32], e.d1);
            chk("rd_busy0", e.id, 32'(rd_busy[0]), 32'(e.b0));
            chk("rd_busy1", e.id, 32'(rd_busy[1]), 32'(e.b1));
            chk("iss_ready", e.id, 32'(iss_ready), 32'(e.rdy));
            chk("err_underflow", e.id, 32'(err_underflow), 32'(e.err));
         end
      end
   end

   initial begin
      m_clear();
      // reset held, then sweep all addresses on both ports
      apply(1'b1, 2'b00, 0, 32'h0, 0, 32'h0, 3, 4, 1'b0, 0);
      apply(1'b1, 2'b11, 5, 32'hAAAA5555, 6, 32'h12345678, 5, 6, 1'b1, 5);
      for (int a = 0; a < DEPTH; a++) idle_read(a, DEPTH - 1 - a);

      // collision on r7 with two outstanding writes
      issue(7, 7);
      issue(7, 7);
      apply(1'b0, 2'b11, 7, 32'h11111111, 7, 32'h22222222, 7, 7, 1'b0, 0);
      idle_read(7, 7);
      apply(1'b0, 2'b01, 7, 32'h33333333, 0, 32'h0, 7, 0, 1'b0, 0);
      idle_read(7, 0);

      // forwarding clears busy for the final outstanding write
      issue(5, 5);
      apply(1'b0, 2'b10, 0, 32'h0, 5, 32'hDEADBEEF, 5, 5, 1'b0, 0);
      idle_read(5, 5);

      // saturation on r3
      issue(3, 3);
      issue(3, 3);
      issue(3, 3);
      issue(3, 3);
      apply(1'b0, 2'b01, 3, 32'hCAFEF00D, 0, 32'h0, 3, 3, 1'b1, 3);
      idle_read(3, 3);

      // underflow on r9, and writes to r0 are ignored
      idle_read(0, 9);
      apply(1'b0, 2'b01, 0, 32'hFFFFFFFF, 0, 32'h0, 0, 0, 1'b0, 0);
      idle_read(0, 9);
      apply(1'b0, 2'b01, 9, 32'h99999999, 0, 32'h0, 9, 0, 1'b0, 0);
      idle_read(9, 0);

      // async reset between edges with r4 pending twice and holding 5
      issue(4, 4);
      issue(4, 4);
      issue(4, 4);
      apply(1'b0, 2'b01, 4, 32'h00000005, 0, 32'h0, 4, 9, 1'b0, 0);
      idle_read(4, 9);
      apply(1'b1, 2'b01, 4, 32'h00000077, 0, 32'h0, 4, 9, 1'b1, 4);
      idle_read(4, 9);
      issue(4, 4);

      // randomized traffic on a small address set to force hazards
      for (int n = 0; n < 400; n++) begin
         apply(($urandom_range(0, 49) == 0),
               2'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)), $urandom,
               int'($urandom_range(0, 7)), $urandom,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with a built-in pending-write scoreboard, replacing the fixed 32×32, 2-read/1-write register file in the pipelined CPU. It provides N_RD combinational read ports with same-cycle write forwarding and N_WR write ports with fixed priority. A per-register pending-write counter is set at issue and cleared at writeback, so the decode stage can stall on RAW hazards without a separate hazard unit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- N_WR, 2, number of write ports (1..4); higher index has priority
- CNT_W, 2, pending-write counter width per register
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rd_addr  in  N_RD*ADDR_W  read addresses, port k in slice k
- rd_data  out  N_RD*DATA_W  read data, combinational
- rd_busy  out  N_RD  register has an outstanding write not satisfied this cycle
- wr_en  in  N_WR  write enables
- wr_addr  in  N_WR*ADDR_W  write addresses
- wr_data  in  N_WR*DATA_W  write data
- iss_en  in  1  instruction issued with a destination register
- iss_addr  in  ADDR_W  destination register of the issued instruction
- iss_ready  out  1  issue is accepted this cycle
- err_underflow  out  1  sticky; set when a write hits a register whose counter is 0

## Operation
- Register 0 reads as 0 and is never busy. Writes to it and issues to it are ignored, with no counter or error effect.
- Read port k, address a≠0:
  - If any wr_en[j] has wr_addr[j]==a, rd_data is wr_data of the highest such j (forwarding).
  - Otherwise rd_data is the stored value.
- Write collision: several ports write the same address in one cycle → the highest index wins. Its counter decrements by 1 only, not once per port.
- Pending counter cnt[a] per register:
  - Issue only → +1.
  - Write only → −1.
  - Both in the same cycle → unchanged.
- iss_ready = 0 only when iss_addr≠0, cnt[iss_addr] is at its maximum (2**CNT_W−1), and no same-cycle write hits iss_addr. A rejected issue leaves all state unchanged; the issuer holds iss_en.
- Write to a register with cnt==0: data is stored, cnt stays 0, and err_underflow sets and remains set until reset.
- rd_busy[k] = cnt[a]≠0, except that it is 0 when cnt[a]==1 and a same-cycle write hits a (the forwarded value is final).
- Reset (asynchronous, possible mid-operation):
  - All registers become 0.
  - All counters become 0.
  - err_underflow becomes 0.
  - In-flight writes in that cycle are discarded.

## Timing
- Reads: 0-cycle latency, purely combinational from rd_addr, wr_*, and stored state.
- Writes and counter updates: visible in stored state after the next posedge; visible on rd_data in the same cycle through forwarding.
- iss_ready: combinational from iss_addr, cnt, and wr_*. The issue takes effect on the posedge where iss_en && iss_ready.
- Output values during and after reset:
  - rd_data = 0 for all addresses.
  - rd_busy = 0.
  - iss_ready = 1.
  - err_underflow = 0.

## Structure
- Package regfile_pkg:
  - default DATA_W, ADDR_W, CNT_W;
  - localparam REG_ZERO = 0;
  - function for the write-priority select (highest hitting port index).
- Sub-module rf_pending_ctr: one CNT_W-bit counter with inc, dec, and at_max/is_zero outputs. It reports underflow; the top level OR-s the reports into the sticky flag. Instantiated 2**ADDR_W−1 times by generate; register 0 has none.
- Top level holds:
  - the data array;
  - read muxes with forwarding;
  - write-priority logic;
  - the sticky error flop.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0, rd_busy=0, iss_ready=1.
- Same-cycle collision: wr_en=2'b11, wr_addr both 7, wr_data0=0x11111111, wr_data1=0x22222222 → rd_data for r7 is 0x22222222 in that cycle and after; cnt[7] decrements once.
- Forwarding and busy: issue r5, next cycle write r5=0xDEADBEEF while reading r5 → rd_data=0xDEADBEEF, rd_busy=0 in that cycle.
- Saturation with CNT_W=2:
  - issue r3 three times → cnt=3; a fourth issue without a write → iss_ready=0 and state unchanged;
  - the same issue alongside a write to r3 → accepted, cnt stays 3.
- Underflow: write r9 with cnt=0 → r9 updated, err_underflow=1 until reset; write to r0 → r0 reads 0, no error.
- Async reset asserted mid-cycle, between clock edges, with cnt[4]=2 and r4=0x5 → all outputs take reset values before the next posedge; r4=0, cnt[4]=0.
